// File: rtl/pipelined_addsub_pkg.sv
// Shared opcodes, flag layout and widths for the pipelined add/subtract unit.
package pipelined_addsub_pkg;

  // Operation select carried on in_op.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Flag bit positions, shared with the condition-code register.
  localparam int unsigned FLAG_CF = 0;
  localparam int unsigned FLAG_OF = 1;
  localparam int unsigned FLAG_ZF = 2;
  localparam int unsigned FLAG_SF = 3;
  localparam int unsigned FLAG_W  = 4;

  // Packed flag word; field order matches the FLAG_* indices (cf is bit 0).
  typedef struct packed {
    logic sf;
    logic zf;
    logic of;
    logic cf;
  } flags_t;

endpackage

// File: rtl/pipelined_addsub_if.sv
// Valid/ready operation and result bus of the pipelined add/subtract unit.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cf;
  logic             out_of;
  logic             out_zf;
  logic             out_sf;
  logic [TAG_W-1:0] out_tag;

  // Issuing side: presents operations, consumes results.
  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cf, out_of, out_zf, out_sf, out_tag
  );

  // Arithmetic unit side.
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cf, out_of, out_zf, out_sf, out_tag
  );

endinterface

// File: rtl/addsub_stage.sv
// One CHUNK-bit adder slice with its pipeline register and local advance logic.
// The final slice also derives the condition flags from the completed result.
module addsub_stage
  import pipelined_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned IDX   = 0,
  parameter bit          LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready_c,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_c,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_op,
  output logic [TAG_W-1:0] out_tag,
  output flags_t           out_flags
);

  localparam int unsigned LO  = IDX * CHUNK;
  localparam int unsigned MSB = WIDTH - 1;

  logic             adv_c;
  logic             carry_c;
  logic [CHUNK-1:0] chunk_c;
  logic [WIDTH-1:0] sum_c;

  // Slice can take new data when empty or when its content leaves this edge.
  always_comb begin
    adv_c      = !out_valid || out_ready;
    in_ready_c = adv_c;
  end

  // Add this slice plus incoming carry and merge it into the partial result.
  always_comb begin
    {carry_c, chunk_c} = (CHUNK+1)'(in_a[LO +: CHUNK])
                       + (CHUNK+1)'(in_b[LO +: CHUNK])
                       + (CHUNK+1)'(in_c);
    sum_c              = in_sum;
    sum_c[LO +: CHUNK] = chunk_c;
  end

  // Valid bit always follows on advance; payload loads only on a real transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_sum   <= '0;
      out_c     <= 1'b0;
      out_op    <= 1'b0;
      out_tag   <= '0;
    end else if (adv_c) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_a   <= in_a;
        out_b   <= in_b;
        out_sum <= sum_c;
        out_c   <= carry_c;
        out_op  <= in_op;
        out_tag <= in_tag;
      end
    end
  end

  if (LAST) begin : g_flags
    flags_t flags_c;

    // Flags from the full result; b here is already inverted for SUB.
    always_comb begin
      flags_c    = '0;
      flags_c.cf = (in_op == OP_SUB) ? !carry_c : carry_c;
      flags_c.of = (in_a[MSB] == in_b[MSB]) && (sum_c[MSB] != in_a[MSB]);
      flags_c.zf = (sum_c == '0);
      flags_c.sf = sum_c[MSB];
    end

    // Flag register, loaded alongside the result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_flags <= '0;
      end else if (adv_c && in_valid) begin
        out_flags <= flags_c;
      end
    end
  end else begin : g_no_flags
    // Intermediate slices never carry meaningful flags.
    assign out_flags = '0;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined signed add/subtract with Y86-style flags: the WIDTH-bit carry chain
// is cut into CHUNK-bit slices, one register stage each, with bubble-collapsing
// valid/ready flow control and a pass-through tag.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_addsub_if.slave  bus
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             v_q;
    logic             rdy_c;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             op_q;
    logic [TAG_W-1:0] t_q;
    flags_t           f_q;

    logic             v_in;
    logic             rdy_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic             op_in;
    logic [TAG_W-1:0] t_in;

    if (i == 0) begin : g_src
      // First slice: invert B and inject carry-in for SUB.
      always_comb begin
        v_in  = bus.in_valid;
        a_in  = bus.in_a;
        b_in  = bus.in_b ^ {WIDTH{bus.in_op == OP_SUB}};
        s_in  = '0;
        c_in  = (bus.in_op == OP_SUB);
        op_in = bus.in_op;
        t_in  = bus.in_tag;
      end
    end else begin : g_src
      // Later slices take the previous slice's register outputs.
      always_comb begin
        v_in  = g_stage[i-1].v_q;
        a_in  = g_stage[i-1].a_q;
        b_in  = g_stage[i-1].b_q;
        s_in  = g_stage[i-1].s_q;
        c_in  = g_stage[i-1].c_q;
        op_in = g_stage[i-1].op_q;
        t_in  = g_stage[i-1].t_q;
      end
    end

    if (i == STAGES - 1) begin : g_dst
      // Last slice is released by the downstream consumer.
      always_comb rdy_in = bus.out_ready;

      logic unused_tail;
      assign unused_tail = ^{a_q, b_q, c_q, op_q};
    end else begin : g_dst
      // Inner slices are released by the next slice.
      always_comb rdy_in = g_stage[i+1].rdy_c;

      logic unused_flags;
      assign unused_flags = ^f_q;
    end

    addsub_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .TAG_W (TAG_W),
      .IDX   (i),
      .LAST  (i == STAGES - 1)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (v_in),
      .in_ready_c (rdy_c),
      .in_a       (a_in),
      .in_b       (b_in),
      .in_sum     (s_in),
      .in_c       (c_in),
      .in_op      (op_in),
      .in_tag     (t_in),
      .out_valid  (v_q),
      .out_ready  (rdy_in),
      .out_a      (a_q),
      .out_b      (b_q),
      .out_sum    (s_q),
      .out_c      (c_q),
      .out_op     (op_q),
      .out_tag    (t_q),
      .out_flags  (f_q)
    );
  end

  // Accept is held off while reset is asserted.
  assign bus.in_ready  = rst_n & g_stage[0].rdy_c;

  // Result side is driven straight from the last slice's registers.
  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.out_sum   = g_stage[STAGES-1].s_q;
  assign bus.out_tag   = g_stage[STAGES-1].t_q;
  assign bus.out_cf    = g_stage[STAGES-1].f_q.cf;
  assign bus.out_of    = g_stage[STAGES-1].f_q.of;
  assign bus.out_zf    = g_stage[STAGES-1].f_q.zf;
  assign bus.out_sf    = g_stage[STAGES-1].f_q.sf;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub with an arithmetic reference model and
// an in-order result scoreboard checked every cycle a result is presented.
module tb_pipelined_addsub;
  import pipelined_addsub_pkg::*;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned CHUNK  = 16;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned STAGES = WIDTH / CHUNK;

  // Expected result; fl is {cf, of, zf, sf}.
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [3:0]       fl;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pipelined_addsub_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  pipelined_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  int   drained     = 0;
  int   stall_occ   = -1;
  bit   stall_armed = 1'b0;
  exp_t q[$];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 65-bit arithmetic and sign rules.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic op, input logic [TAG_W-1:0] tag);
    exp_t        e;
    logic [WIDTH:0] full;
    logic        ovf;
    if (op == OP_SUB) begin
      full = {1'b0, a} - {1'b0, b};
      ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b};
      ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    end
    e.sum = full[WIDTH-1:0];
    e.fl  = {full[WIDTH], ovf, (full[WIDTH-1:0] == '0), full[WIDTH-1]};
    e.tag = tag;
    return e;
  endfunction

  function automatic logic [3:0] dut_fl();
    return {bus.out_cf, bus.out_of, bus.out_zf, bus.out_sf};
  endfunction

  // Scoreboard: push on accept, compare head whenever a result is shown.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
      end else begin
        if (stall_armed && !bus.in_ready) begin
          stall_occ   = q.size();
          stall_armed = 1'b0;
        end
        if (q.size() == 0) begin
          check("mon_no_spurious_valid", WIDTH'(bus.out_valid), '0);
        end else if (bus.out_valid) begin
          check("mon_sum", bus.out_sum, q[0].sum);
          check("mon_flags", WIDTH'(dut_fl()), WIDTH'(q[0].fl));
          check("mon_tag", WIDTH'(bus.out_tag), WIDTH'(q[0].tag));
          if (bus.out_ready) begin
            void'(q.pop_front());
            drained++;
          end
        end
        if (bus.in_valid && bus.in_ready)
          q.push_back(model(bus.in_a, bus.in_b, bus.in_op, bus.in_tag));
      end
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic op, input logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_tag   = tag;
  endtask

  // Single op with literal expectations and latency measurement.
  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic op, input logic [TAG_W-1:0] tag,
                        input logic [WIDTH-1:0] esum, input logic [3:0] efl);
    bit acc;
    int lat;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(a, b, op, tag);
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (!acc) begin @(posedge clk); #1; end
    end
    check({name, "_accept"}, WIDTH'(acc), WIDTH'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
    check({name, "_latency"}, WIDTH'(lat), WIDTH'(STAGES));
    check({name, "_sum"}, bus.out_sum, esum);
    check({name, "_flags"}, WIDTH'(dut_fl()), WIDTH'(efl));
    check({name, "_tag"}, WIDTH'(bus.out_tag), WIDTH'(tag));
  endtask

  function automatic logic [WIDTH-1:0] bp_a(input int i);
    return 64'h0123_4567_89AB_CDEF * WIDTH'(i + 1);
  endfunction

  function automatic logic [WIDTH-1:0] bp_b(input int i);
    logic [WIDTH-1:0] base;
    base = 64'hFEDC_BA98_7654_3210;
    return base >> i;
  endfunction

  initial begin
    int idx;
    int cyc;
    int drained0;
    bit acc;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", WIDTH'(bus.out_valid), '0);
    check("rst_out_sum", bus.out_sum, '0);
    check("rst_flags", WIDTH'(dut_fl()), '0);
    check("rst_out_tag", WIDTH'(bus.out_tag), '0);
    check("rst_in_ready", WIDTH'(bus.in_ready), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));

    // Directed arithmetic with hand-computed results
    run_op("add_basic", 64'd222222, 64'd11111111111, OP_ADD, 4'h1, 64'd11111333333, 4'b0000);
    run_op("add_chunk_carry", 64'h0000_0000_0000_FFFF, 64'd1, OP_ADD, 4'h2, 64'h0000_0000_0001_0000, 4'b0000);
    run_op("add_signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 4'h3, 64'h8000_0000_0000_0000, 4'b0101);
    run_op("add_wrap_zero", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 4'h4, 64'h0, 4'b1010);
    run_op("sub_equal", 64'd5, 64'd5, OP_SUB, 4'h5, 64'h0, 4'b0010);
    run_op("sub_borrow", 64'd3, 64'd5, OP_SUB, 4'h6, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1001);
    run_op("sub_signed_ovf", 64'h8000_0000_0000_0000, 64'd1, OP_SUB, 4'h7, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0100);

    // Back-to-back ops with a downstream stall
    @(posedge clk); #1;
    drained0      = drained;
    stall_occ     = -1;
    stall_armed   = 1'b1;
    bus.out_ready = 1'b1;
    idx = 0;
    cyc = 0;
    drive(bp_a(0), bp_b(0), 1'b0, 4'h0);
    while (idx < 8 && cyc < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      bus.out_ready = !(cyc >= 3 && cyc <= 8);
      if (acc) begin
        idx++;
        if (idx < 8) drive(bp_a(idx), bp_b(idx), idx[0], TAG_W'(idx));
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_all_issued", WIDTH'(idx), WIDTH'(8));
    for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check("bp_queue_empty", WIDTH'(q.size()), '0);
    check("bp_drained_count", WIDTH'(drained - drained0), WIDTH'(8));
    check("bp_stall_occupancy", WIDTH'(stall_occ), WIDTH'(STAGES));

    // Reset while three ops are in flight
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      drive(bp_a(j + 3), 64'd77 * WIDTH'(j + 1), 1'(j), TAG_W'(j + 9));
      @(negedge clk);
      check("rf_accept", WIDTH'(bus.in_ready), WIDTH'(1));
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check("rf_pre_valid", WIDTH'(bus.out_valid), WIDTH'(1));
    rst_n = 1'b0;
    #1;
    check("rf_valid_cleared", WIDTH'(bus.out_valid), '0);
    check("rf_in_ready_low", WIDTH'(bus.in_ready), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("rf_no_result", WIDTH'(bus.out_valid), '0);
    end

    // Pipeline still usable after the mid-flight reset
    run_op("post_rf_add", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, OP_ADD, 4'hA,
           64'h0001_0000_0001_0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined signed add/subtract unit. It succeeds the fixed 64-bit combinational adder in the execute path.
- Splits the WIDTH-bit carry chain into CHUNK-bit slices, one register stage per slice. This breaks the long carry path for timing.
- Produces Y86-style condition flags (CF, OF, ZF, SF) alongside the result.
- Uses valid/ready handshakes on both sides and carries a tag so results can be matched to the issuing instruction.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 16, bits added per pipeline stage.
- TAG_W, 4, width of the pass-through tag.
- STAGES (localparam), WIDTH/CHUNK, pipeline depth and latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  unit accepts the operation this cycle.
- in_a  input  WIDTH  operand A, two's complement.
- in_b  input  WIDTH  operand B, two's complement.
- in_op  input  1  0 = ADD (A+B), 1 = SUB (A−B).
- in_tag  input  TAG_W  opaque tag, returned with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream consumes the result.
- out_sum  output  WIDTH  result.
- out_cf  output  1  unsigned carry (ADD) / borrow (SUB).
- out_of  output  1  signed overflow.
- out_zf  output  1  result == 0.
- out_sf  output  1  result MSB.
- out_tag  output  TAG_W  tag of this result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all stage valid bits, data, carry and tag registers clear to 0. Therefore out_valid, out_sum, all flags and out_tag are 0. in_ready is forced to 0 while rst_n is low.
- Handshake:
  - A transfer occurs on an edge where valid && ready.
  - in_a, in_b, in_op and in_tag are sampled only on an input transfer.
  - out_* must stay stable while out_valid && !out_ready.
- Pipeline control (bubble-collapsing):
  - Stage i advances when !valid_i || ready_{i+1}.
  - ready_{STAGES} = out_ready.
  - in_ready = ready_0 = !valid_0 || ready_1, combinational; there is no combinational path from in_valid.
- Stage 0:
  - Forms b' = in_b XOR {WIDTH{in_op}} and carry-in = in_op.
  - Adds chunk 0 of A and b'.
  - Registers the sum chunk, the carry out, the unconsumed upper chunks of A and b', the sign bits of A and b', and the tag.
- Stage k (1 ≤ k < STAGES): adds chunk k plus the registered carry, writes the chunk into the partial result, and forwards the carry.
- Latency: exactly STAGES cycles from an input transfer to out_valid, given no stall.
- Throughput: one operation per cycle when out_ready = 1.
- Flags, computed in the final stage from the full result:
  - ADD: CF = carry out of MSB.
  - SUB: CF = NOT carry out, i.e. 1 iff unsigned A < unsigned B.
  - OF = (sA == sB') && (sum[MSB] != sA).
  - ZF = (sum == 0).
  - SF = sum[MSB].
- Wrap-around: the result is modulo 2^WIDTH. Overflow is only flagged, never saturated.
- Simultaneous events:
  - With a full pipeline and out_ready = 1, an input is accepted in the same cycle the output drains.
  - Bubbles anywhere collapse, so later entries advance into empty stages while out_ready = 0.
- Full pipeline with out_ready = 0: in_ready = 0 and nothing is lost or reordered.
- Reset mid-operation: all in-flight operations are discarded immediately (asynchronous). No result for them ever appears after rst_n rises.
- STAGES = 1 (CHUNK = WIDTH) is legal: a single registered stage with latency 1.

Decomposition:
- Shared package/header pipelined_addsub_pkg holds:
  - OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - Flag bit indices FLAG_CF/OF/ZF/SF, reused by the condition-code register.
- Sub-module addsub_stage: one CHUNK-bit adder slice plus its valid/data/carry/tag register and local advance logic. It is instantiated STAGES times via generate. The last instance also computes the flags.

Test Plan:
1. Reset: hold rst_n = 0 for 3 cycles → out_valid = 0, out_sum = 0, all flags 0, in_ready = 0. After release, in_ready = 1.
2. ADD A = 222222, B = 11111111111, out_ready = 1 → out_sum = 11111333333 with CF = OF = ZF = SF = 0, out_valid exactly 4 cycles after acceptance (defaults).
3. Boundary carries:
   - ADD A = 64'h0000_0000_0000_FFFF, B = 1 → 64'h10000, all flags 0.
   - ADD A = 64'h7FFF_FFFF_FFFF_FFFF, B = 1 → 64'h8000_0000_0000_0000, OF = 1, SF = 1, CF = 0.
   - ADD A = −1, B = 1 → 0, ZF = 1, CF = 1, OF = 0.
4. SUB:
   - A = 5, B = 5 → 0, ZF = 1, CF = 0.
   - A = 3, B = 5 → −2, SF = 1, CF = 1.
   - A = 64'h8000_0000_0000_0000, B = 1 → 64'h7FFF_FFFF_FFFF_FFFF, OF = 1.
5. Backpressure: issue 8 back-to-back ops with tags 0–7 and hold out_ready = 0 for cycles 3–8 → in_ready falls after 4 entries are held. All 8 results emerge in tag order, each matching the reference sum, with none dropped or duplicated.
6. Reset mid-flight: after 3 ops are accepted, pulse rst_n low for 1 cycle → out_valid = 0 immediately and stays 0 for 10 cycles with no new input.
